// File: rtl/audio_fir_ctrl.sv
// Frame sequencer between the CODEC FIFO handshake and a stereo pair of
// moving-average filters, with bypass mode and filter history flushing.
module audio_fir_ctrl #(
   parameter int unsigned N           = 16,
   parameter int unsigned FIR_LATENCY = 1,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 filter_en,
   input  logic                 read_ready,
   input  logic                 write_ready,
   input  logic [23:0]          readdata_left,
   input  logic [23:0]          readdata_right,
   output logic                 read,
   output logic                 write,
   output logic [23:0]          writedata_left,
   output logic [23:0]          writedata_right,
   output logic                 fir_step,
   output logic [23:0]          fir_in_left,
   output logic [23:0]          fir_in_right,
   input  logic [23:0]          fir_out_left,
   input  logic [23:0]          fir_out_right,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] sample_count
);

   localparam int unsigned DW  = 24;
   localparam int unsigned FCW = $clog2(N + 1);
   localparam int unsigned LW  = 3;

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_WAIT_IN, S_CAPTURE, S_STEP, S_LAT, S_WAIT_WR, S_WRITE
   } state_t;

   state_t               state_q, state_d;
   logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
   logic [LW-1:0]        lat_cnt_q, lat_cnt_d;
   logic                 en_s1_q, en_s1_d, en_s2_q, en_s2_d, en_s3_q, en_s3_d;
   logic                 flush_pend_q, flush_pend_d;
   logic                 read_q, read_d, write_q, write_d, step_q, step_d;
   logic                 busy_q, busy_d;
   logic [DW-1:0]        fin_l_q, fin_l_d, fin_r_q, fin_r_d;
   logic [DW-1:0]        wd_l_q, wd_l_d, wd_r_q, wd_r_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 en_rise;

   assign en_rise = en_s2_q & ~en_s3_q;

   // Next-state and next-output decode
   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      en_s1_d      = filter_en;
      en_s2_d      = en_s1_q;
      en_s3_d      = en_s2_q;
      flush_pend_d = flush_pend_q | en_rise;
      fin_l_d      = fin_l_q;
      fin_r_d      = fin_r_q;
      wd_l_d       = wd_l_q;
      wd_r_d       = wd_r_q;
      cnt_d        = cnt_q;

      case (state_q)
         S_IDLE: begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
         end
         S_FLUSH: begin
            if (flush_cnt_q == FCW'(N - 1)) state_d = S_WAIT_IN;
            else flush_cnt_d = flush_cnt_q + FCW'(1);
         end
         S_WAIT_IN: begin
            if (flush_pend_q) begin
               flush_pend_d = en_rise;
               flush_cnt_d  = '0;
               state_d      = S_FLUSH;
            end else if (read_ready) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            fin_l_d = readdata_left;
            fin_r_d = readdata_right;
            if (en_s2_q) begin
               state_d = S_STEP;
            end else begin
               wd_l_d  = readdata_left;
               wd_r_d  = readdata_right;
               state_d = S_WAIT_WR;
            end
         end
         S_STEP: begin
            lat_cnt_d = LW'(FIR_LATENCY);
            state_d   = S_LAT;
         end
         S_LAT: begin
            lat_cnt_d = lat_cnt_q - LW'(1);
            if (lat_cnt_q == LW'(1)) begin
               wd_l_d  = fir_out_left;
               wd_r_d  = fir_out_right;
               state_d = S_WAIT_WR;
            end
         end
         S_WAIT_WR: begin
            if (write_ready) state_d = S_WRITE;
         end
         S_WRITE: begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = S_WAIT_IN;
         end
         default: state_d = S_IDLE;
      endcase

      // Flush steps feed zeros so the filter history is cleared
      if (state_d == S_FLUSH) begin
         fin_l_d = '0;
         fin_r_d = '0;
      end

      read_d  = (state_d == S_CAPTURE);
      write_d = (state_d == S_WRITE);
      step_d  = (state_d == S_FLUSH) || (state_d == S_STEP);
      busy_d  = (state_d != S_WAIT_IN);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         flush_cnt_q  <= '0;
         lat_cnt_q    <= '0;
         en_s1_q      <= 1'b0;
         en_s2_q      <= 1'b0;
         en_s3_q      <= 1'b0;
         flush_pend_q <= 1'b0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         step_q       <= 1'b0;
         busy_q       <= 1'b1;
         fin_l_q      <= '0;
         fin_r_q      <= '0;
         wd_l_q       <= '0;
         wd_r_q       <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         en_s1_q      <= en_s1_d;
         en_s2_q      <= en_s2_d;
         en_s3_q      <= en_s3_d;
         flush_pend_q <= flush_pend_d;
         read_q       <= read_d;
         write_q      <= write_d;
         step_q       <= step_d;
         busy_q       <= busy_d;
         fin_l_q      <= fin_l_d;
         fin_r_q      <= fin_r_d;
         wd_l_q       <= wd_l_d;
         wd_r_q       <= wd_r_d;
         cnt_q        <= cnt_d;
      end
   end

   assign read            = read_q;
   assign write           = write_q;
   assign fir_step        = step_q;
   assign busy            = busy_q;
   assign fir_in_left     = fin_l_q;
   assign fir_in_right    = fin_r_q;
   assign writedata_left  = wd_l_q;
   assign writedata_right = wd_r_q;
   assign sample_count    = cnt_q;

endmodule

// File: tb/tb_audio_fir_ctrl.sv
// Directed bench for audio_fir_ctrl: 16-tap moving-average filter model,
// write-data scoreboard, and frame timing / flush / wrap checks.
module tb_audio_fir_ctrl;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset, filter_en, read_ready, write_ready;
   logic [23:0]   rdl, rdr, wdl, wdr, fil, fir, fol, forr;
   logic          read, write, fir_step, busy;
   logic [CW-1:0] sample_count;

   int checks = 0, failures = 0;
   int cyc = 0, n_read = 0, n_write = 0, n_step = 0;
   logic [47:0] exp_q[$];

   always #5 clk = ~clk;

   audio_fir_ctrl #(.N(16), .FIR_LATENCY(1), .CNT_WIDTH(CW)) dut (
      .CLOCK_50(clk), .reset(reset), .filter_en(filter_en),
      .read_ready(read_ready), .write_ready(write_ready),
      .readdata_left(rdl), .readdata_right(rdr),
      .read(read), .write(write),
      .writedata_left(wdl), .writedata_right(wdr),
      .fir_step(fir_step), .fir_in_left(fil), .fir_in_right(fir),
      .fir_out_left(fol), .fir_out_right(forr),
      .busy(busy), .sample_count(sample_count)
   );

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // 16-tap moving average, output registered one cycle after the step
   logic [23:0] hist_l [16] = '{default: 24'd0};
   logic [23:0] hist_r [16] = '{default: 24'd0};
   initial begin
      fol  = 24'd0;
      forr = 24'd0;
   end
   always @(posedge clk) begin : fir_model
      logic signed [27:0] sl, sr;
      if (fir_step) begin
         sl = {{4{fil[23]}}, fil};
         sr = {{4{fir[23]}}, fir};
         for (int k = 0; k < 15; k++) begin
            sl = sl + {{4{hist_l[k][23]}}, hist_l[k]};
            sr = sr + {{4{hist_r[k][23]}}, hist_r[k]};
         end
         for (int k = 15; k > 0; k--) begin
            hist_l[k] <= hist_l[k-1];
            hist_r[k] <= hist_r[k-1];
         end
         hist_l[0] <= fil;
         hist_r[0] <= fir;
         fol  <= 24'(sl >>> 4);
         forr <= 24'(sr >>> 4);
      end
   end

   // Per-cycle monitor: event counts, one-hot strobes, scoreboard pop
   always @(posedge clk) begin
      #2;
      cyc++;
      if (read) n_read++;
      if (write) n_write++;
      if (fir_step) n_step++;
      chk("onehot", 48'($countones({read, write, fir_step}) <= 1), 48'd1);
      if (write) begin
         if (exp_q.size() == 0) chk("sb_empty", 48'd1, 48'd0);
         else chk("writedata", {wdl, wdr}, exp_q.pop_front());
      end
   end

   task automatic wait_for(input int sel, input string tag, output int waited);
      waited = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if ((sel == 0 && read) || (sel == 1 && write) || (sel == 2 && fir_step)) begin
            waited = k;
            return;
         end
      end
      chk({tag, "_timeout"}, 48'd0, 48'd1);
   endtask

   task automatic flush_check(input string tag, output int waited);
      int run;
      logic zero_ok;
      wait_for(2, tag, waited);
      run = 0;
      zero_ok = 1'b1;
      while (fir_step && run < 40) begin
         if (fil !== 24'd0 || fir !== 24'd0) zero_ok = 1'b0;
         run++;
         @(negedge clk);
      end
      chk({tag, "_len"}, 48'(run), 48'd16);
      chk({tag, "_zero"}, 48'(zero_ok), 48'd1);
      chk({tag, "_busy"}, 48'(busy), 48'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, r0, s0, w0, rd0;
      logic ok;
      reset = 1'b0; filter_en = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
      rdl = 24'd0; rdr = 24'd0;

      // Reset and initial flush
      repeat (3) @(negedge clk);
      chk("rst_ctl", 48'({read, write, fir_step}), 48'd0);
      chk("rst_wd", {wdl, wdr}, 48'd0);
      chk("rst_fin", {fil, fir}, 48'd0);
      chk("rst_cnt", 48'(sample_count), 48'd0);
      reset = 1'b1;
      flush_check("init_flush", w);
      chk("idle_cycles", 48'(w), 48'd1);

      // Filtered frames: enabling filters triggers a flush first
      filter_en = 1'b1;
      flush_check("en_flush", w);
      exp_q.push_back({24'h000040, 24'hFFFFC0});
      exp_q.push_back({24'h000080, 24'hFFFF80});
      rdl = 24'h000400; rdr = 24'hFFFC00;
      write_ready = 1'b1; read_ready = 1'b1;
      wait_for(0, "f1_read", w);
      r0 = cyc;
      @(negedge clk);
      chk("f1_step", 48'(fir_step), 48'd1);
      chk("f1_fin", {fil, fir}, {24'h000400, 24'hFFFC00});
      wait_for(1, "f1_write", w);
      chk("f1_wr_lat", 48'(cyc - r0), 48'd4);
      @(negedge clk);
      chk("f1_cnt", 48'(sample_count), 48'd1);
      wait_for(0, "f2_read", w);
      chk("f_period", 48'(cyc - r0), 48'd6);
      read_ready = 1'b0;
      wait_for(1, "f2_write", w);
      @(negedge clk);
      chk("f2_cnt", 48'(sample_count), 48'd2);

      // Bypass with a write stall; the 1->0 switch must not flush
      filter_en = 1'b0;
      s0 = n_step;
      repeat (4) @(negedge clk);
      write_ready = 1'b0;
      rdl = 24'h123456; rdr = 24'h654321;
      exp_q.push_back({24'h123456, 24'h654321});
      read_ready = 1'b1;
      wait_for(0, "b_read", w);
      r0 = cyc;
      read_ready = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wdl !== 24'h123456 || write !== 1'b0) ok = 1'b0;
      end
      chk("b_stall", 48'(ok), 48'd1);
      w0 = n_write;
      write_ready = 1'b1;
      @(negedge clk);
      chk("b_write", 48'(write), 48'd1);
      @(negedge clk);
      chk("b_write_once", 48'(n_write - w0), 48'd1);
      chk("b_no_step", 48'(n_step - s0), 48'd0);
      chk("b_cnt", 48'(sample_count), 48'd3);
      chk("b_period_ok", 48'(cyc - r0 >= 12), 48'd1);

      // Mode switch during WAIT_WR: bypass completes, then flush, then filtered
      rdl = 24'h000800; rdr = 24'hFFF800;
      exp_q.push_back({24'h000800, 24'hFFF800});
      exp_q.push_back({24'h000080, 24'hFFFF80});
      write_ready = 1'b0; read_ready = 1'b1;
      s0 = n_step;
      wait_for(0, "m_read", w);
      @(negedge clk);
      filter_en = 1'b1;
      repeat (5) @(negedge clk);
      write_ready = 1'b1;
      wait_for(1, "m_write", w);
      chk("m_bypass_no_step", 48'(n_step - s0), 48'd0);
      rd0 = n_read;
      flush_check("m_flush", w);
      chk("m_no_read_in_flush", 48'(n_read - rd0), 48'd0);
      wait_for(0, "m_read2", w);
      read_ready = 1'b0;
      wait_for(1, "m_write2", w);
      @(negedge clk);
      chk("m_cnt", 48'(sample_count), 48'd5);

      // Reset while in LAT: frame discarded, counter cleared, flush repeats
      read_ready = 1'b1;
      wait_for(0, "r_read", w);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0; filter_en = 1'b0; read_ready = 1'b0;
      w0 = n_write;
      repeat (2) @(negedge clk);
      chk("r_cnt", 48'(sample_count), 48'd0);
      chk("r_ctl", 48'({read, write, fir_step}), 48'd0);
      reset = 1'b1;
      flush_check("r_flush", w);
      chk("r_idle_cycles", 48'(w), 48'd1);
      chk("r_no_write", 48'(n_write - w0), 48'd0);

      // Counter wrap over 17 bypass frames
      write_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         rdl = 24'(32'h00A000 + 32'(i));
         rdr = ~rdl;
         exp_q.push_back({rdl, rdr});
         read_ready = 1'b1;
         wait_for(0, "w_read", w);
         @(negedge clk);
         if (i == 16) read_ready = 1'b0;
         wait_for(1, "w_write", w);
         @(negedge clk);
         chk("w_cnt", 48'(sample_count), 48'((i + 1) % 16));
      end

      repeat (4) @(negedge clk);
      chk("sb_drained", 48'(exp_q.size()), 48'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
